// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader and the compute array that
// reads its flat output bus.
//   DefDataW    - default element width
//   order_e     - fill order of one load (row-major / column-major)
//   loader_state_e - loader FSM states
//   elem_offset - bit offset of element (r,c) inside a flat ROWS*COLS*DATA_W bus
package matrix_pkg;

  localparam int unsigned DefDataW = 32;

  typedef enum logic {
    OrderRow = 1'b0,
    OrderCol = 1'b1
  } order_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitBank
  } loader_state_e;

  // Element (r,c) occupies bits [offset + data_w - 1 : offset].
  function automatic int unsigned elem_offset(input int unsigned r, input int unsigned c,
                                              input int unsigned cols,
                                              input int unsigned data_w);
    return (r * cols + c) * data_w;
  endfunction

endpackage

// File: rtl/matrix_bank.sv
// One ROWS x COLS register bank of DATA_W-bit elements.
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low clear of all elements
//   we_i    - write wdata_i into element (row_i, col_i)
//   row_i   - row index of the write
//   col_i   - column index of the write
//   wdata_i - element data
//   data_o  - whole bank, element (r,c) at elem_offset(r, c, COLS, DATA_W)
module matrix_bank
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          we_i,
  input  logic [CNT_W-1:0]              row_i,
  input  logic [CNT_W-1:0]              col_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [ROWS*COLS*DATA_W-1:0]   data_o
);

  logic [ROWS*COLS*DATA_W-1:0] data_q, data_d;

  // Per-element decode keeps every part-select constant.
  always_comb begin
    data_d = data_q;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (we_i && (row_i == CNT_W'(r)) && (col_i == CNT_W'(c))) begin
          data_d[elem_offset(r, c, COLS, DATA_W) +: DATA_W] = wdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/matrix_b_dbuf_loader.sv
// Double-buffered matrix operand loader. Streams ROWS*COLS elements over a
// valid/ready handshake into the fill bank while the consumer reads the other.
//   clk, n_reset  - clock and synchronous active-low reset
//   start         - begin a load into the fill bank; col_major sampled with it
//   in_valid/in_data/in_ready - element stream
//   mat_valid     - read bank holds a complete matrix
//   mat_release   - consumer done with the read bank
//   Data_out      - read-bank matrix, zero while mat_valid is low
//   Busy          - LOAD or WAIT_BANK
//   load_done     - pulse in the cycle after the last element is written
//   err_start     - pulse in the cycle after a start seen while busy
module matrix_b_dbuf_loader
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        start,
  input  logic                        col_major,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        mat_valid,
  input  logic                        mat_release,
  output logic [ROWS*COLS*DATA_W-1:0] Data_out,
  output logic                        Busy,
  output logic                        load_done,
  output logic                        err_start
);

  localparam int unsigned MaxDim = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned CntW   = (MaxDim > 2) ? $clog2(MaxDim) : 1;

  loader_state_e  state_q, state_d;
  order_e         order_q, order_d;
  logic [1:0]     bank_full_q, bank_full_d;
  logic           fill_bank_q, fill_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [CntW-1:0] r_q, r_d, c_q, c_d;
  logic           load_done_q, load_done_d;
  logic           err_start_q, err_start_d;

  logic [1:0]     bank_we;
  logic [ROWS*COLS*DATA_W-1:0] bank_data [2];
  logic           handshake, release_fire, r_last, c_last;

  assign in_ready     = (state_q == StLoad);
  assign handshake    = in_valid & in_ready;
  assign mat_valid    = bank_full_q[rd_bank_q];
  assign release_fire = mat_release & mat_valid;
  assign r_last       = (r_q == CntW'(ROWS - 1));
  assign c_last       = (c_q == CntW'(COLS - 1));

  always_comb begin
    state_d     = state_q;
    order_d     = order_q;
    bank_full_d = bank_full_q;
    fill_bank_d = fill_bank_q;
    rd_bank_d   = rd_bank_q;
    r_d         = r_q;
    c_d         = c_q;
    load_done_d = 1'b0;
    err_start_d = 1'b0;
    bank_we     = 2'b00;

    // Release first so a waiting load can see the bank free on this edge.
    if (release_fire) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          order_d = col_major ? OrderCol : OrderRow;
          state_d = bank_full_q[fill_bank_q] ? StWaitBank : StLoad;
        end
      end
      StWaitBank: begin
        err_start_d = start;
        if (!bank_full_d[fill_bank_q]) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        err_start_d = start;
        if (handshake) begin
          bank_we[fill_bank_q] = 1'b1;
          // The last element is (ROWS-1, COLS-1) in either fill order.
          if (r_last && c_last) begin
            bank_full_d[fill_bank_q] = 1'b1;
            fill_bank_d              = ~fill_bank_q;
            r_d                      = '0;
            c_d                      = '0;
            load_done_d              = 1'b1;
            state_d                  = StIdle;
          end else if (order_q == OrderRow) begin
            if (c_last) begin
              c_d = '0;
              r_d = r_q + 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
          end else begin
            if (r_last) begin
              r_d = '0;
              c_d = c_q + 1'b1;
            end else begin
              r_d = r_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      order_q     <= OrderRow;
      bank_full_q <= 2'b00;
      fill_bank_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      load_done_q <= 1'b0;
      err_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      order_q     <= order_d;
      bank_full_q <= bank_full_d;
      fill_bank_q <= fill_bank_d;
      rd_bank_q   <= rd_bank_d;
      r_q         <= r_d;
      c_q         <= c_d;
      load_done_q <= load_done_d;
      err_start_q <= err_start_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    matrix_bank #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .DATA_W (DATA_W),
      .CNT_W  (CntW)
    ) u_bank (
      .clk_i   (clk),
      .rst_ni  (n_reset),
      .we_i    (bank_we[b]),
      .row_i   (r_q),
      .col_i   (c_q),
      .wdata_i (in_data),
      .data_o  (bank_data[b])
    );
  end

  assign Data_out  = mat_valid ? bank_data[rd_bank_q] : '0;
  assign Busy      = (state_q != StIdle);
  assign load_done = load_done_q;
  assign err_start = err_start_q;

endmodule

// File: tb/tb_matrix_b_dbuf_loader.sv
module tb_matrix_b_dbuf_loader;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         start, col_major, in_valid, mat_release;
  logic [31:0]  in_data;
  logic         in_ready, mat_valid, Busy, load_done, err_start;
  logic [511:0] Data_out;

  // Second instance: non-square 2x3 with 8-bit elements.
  logic         s_start, s_col_major, s_in_valid, s_mat_release;
  logic [7:0]   s_in_data;
  logic         s_in_ready, s_mat_valid, s_Busy, s_load_done, s_err_start;
  logic [47:0]  s_Data_out;

  int           checks = 0;
  int           failures = 0;
  logic [511:0] exp_q[$];
  logic [31:0]  vals[16];
  int           rc;

  always #5 clk = ~clk;

  matrix_b_dbuf_loader #(.ROWS(4), .COLS(4), .DATA_W(32)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (start),
    .col_major   (col_major),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mat_valid   (mat_valid),
    .mat_release (mat_release),
    .Data_out    (Data_out),
    .Busy        (Busy),
    .load_done   (load_done),
    .err_start   (err_start)
  );

  matrix_b_dbuf_loader #(.ROWS(2), .COLS(3), .DATA_W(8)) dut2 (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (s_start),
    .col_major   (s_col_major),
    .in_valid    (s_in_valid),
    .in_data     (s_in_data),
    .in_ready    (s_in_ready),
    .mat_valid   (s_mat_valid),
    .mat_release (s_mat_release),
    .Data_out    (s_Data_out),
    .Busy        (s_Busy),
    .load_done   (s_load_done),
    .err_start   (s_err_start)
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference placement uses division/modulo, independent of the RTL counters.
  function automatic logic [511:0] build_mat(input logic [31:0] base, input logic cm);
    logic [511:0] m = '0;
    for (int k = 0; k < 16; k++) begin
      int r = cm ? (k % 4) : (k / 4);
      int c = cm ? (k / 4) : (k % 4);
      m[(r * 4 + c) * 32 +: 32] = base + 32'(k);
    end
    return m;
  endfunction

  function automatic logic [31:0] elem(input logic [511:0] m, input int r, input int c);
    return m[(r * 4 + c) * 32 +: 32];
  endfunction

  task automatic set_vals(input logic [31:0] base);
    for (int k = 0; k < 16; k++) vals[k] = base + 32'(k);
  endtask

  task automatic do_start(input logic cm);
    start     = 1'b1;
    col_major = cm;
    tick();
    start     = 1'b0;
    col_major = 1'b0;
  endtask

  // Drive vals[] until stop_at handshakes; in_valid asserted once per 'period'
  // cycles. Pulses start in the cycle where the handshake count equals err_at.
  task automatic feed(input int period, input int err_at, input int stop_at,
                      output int ready_cycles);
    int  k = 0;
    int  cyc = 0;
    bit  pulsed = 0;
    ready_cycles = 0;
    while (k < stop_at && cyc < 500) begin
      in_valid = (cyc % period == 0);
      in_data  = vals[k];
      if (k == err_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end
      if (in_ready) ready_cycles++;
      if (in_ready && in_valid) k++;
      tick();
      if (start) begin
        start = 1'b0;
        check_eq("err_start_pulse", err_start, 1'b1);
        check_eq("busy_after_err", Busy, 1'b1);
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (k < stop_at) check_eq("feed_timeout", k, stop_at);
  endtask

  // Wait for a complete matrix, compare with scoreboard head, release it.
  task automatic consume(input string tag);
    int n = 0;
    while (!mat_valid && n < 50) begin
      tick();
      n++;
    end
    if (!mat_valid) begin
      check_eq({tag, "_timeout"}, mat_valid, 1'b1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, 1'b1, 1'b0);
      return;
    end
    check_eq(tag, Data_out, exp_q.pop_front());
    mat_release = 1'b1;
    tick();
    mat_release = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_in_ready"}, in_ready, 1'b0);
    check_eq({pfx, "_mat_valid"}, mat_valid, 1'b0);
    check_eq({pfx, "_data_out"}, Data_out, '0);
    check_eq({pfx, "_busy"}, Busy, 1'b0);
    check_eq({pfx, "_load_done"}, load_done, 1'b0);
    check_eq({pfx, "_err_start"}, err_start, 1'b0);
  endtask

  initial begin
    n_reset = 1'b0; start = 0; col_major = 0; in_valid = 0; in_data = '0; mat_release = 0;
    s_start = 0; s_col_major = 0; s_in_valid = 0; s_in_data = '0; s_mat_release = 0;
    tick();
    tick();
    check_all_zero("reset");
    n_reset = 1'b1;
    tick();

    // Row-major 0x10..0x1F, in_valid held high.
    set_vals(32'h10);
    do_start(1'b0);
    exp_q.push_back(build_mat(32'h10, 1'b0));
    feed(1, -1, 16, rc);
    check_eq("row_ready_cycles", rc, 16);
    check_eq("row_load_done", load_done, 1'b1);
    check_eq("row_mat_valid", mat_valid, 1'b1);
    check_eq("row_in_ready_low", in_ready, 1'b0);
    check_eq("row_elem_1_2", elem(Data_out, 1, 2), 32'h16);
    consume("row_matrix");
    check_eq("row_load_done_pulse", load_done, 1'b0);
    check_eq("row_released_valid", mat_valid, 1'b0);
    check_eq("row_released_data", Data_out, '0);

    // Column-major 0..15.
    set_vals(32'h0);
    do_start(1'b1);
    exp_q.push_back(build_mat(32'h0, 1'b1));
    feed(1, -1, 16, rc);
    check_eq("col_elem_1_2", elem(Data_out, 1, 2), 32'd9);
    check_eq("col_elem_3_0", elem(Data_out, 3, 0), 32'd3);
    consume("col_matrix");

    // A then B back to back, third load waits for a bank.
    set_vals(32'h100);
    do_start(1'b0);
    exp_q.push_back(build_mat(32'h100, 1'b0));
    feed(1, -1, 16, rc);
    set_vals(32'h200);
    do_start(1'b1);
    exp_q.push_back(build_mat(32'h200, 1'b1));
    feed(1, -1, 16, rc);
    check_eq("ab_b_done", load_done, 1'b1);
    do_start(1'b0);
    check_eq("wait_busy", Busy, 1'b1);
    check_eq("wait_in_ready", in_ready, 1'b0);
    tick();
    check_eq("wait_still", in_ready, 1'b0);
    check_eq("wait_shows_a", Data_out, exp_q[0]);
    consume("ab_matrix_a");
    check_eq("wait_to_load", in_ready, 1'b1);
    check_eq("ab_shows_b", Data_out, exp_q[0]);
    set_vals(32'h300);
    exp_q.push_back(build_mat(32'h300, 1'b0));
    feed(1, -1, 16, rc);
    check_eq("c_ready_cycles", rc, 16);
    consume("ab_matrix_b");
    consume("ab_matrix_c");

    // Dropped data in IDLE, then start mid-load after 5 elements.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    check_eq("idle_drop_no_err", err_start, 1'b0);
    in_valid = 1'b0;
    set_vals(32'h400);
    do_start(1'b0);
    exp_q.push_back(build_mat(32'h400, 1'b0));
    feed(1, 5, 16, rc);
    check_eq("err_ready_cycles", rc, 16);
    check_eq("err_load_done", load_done, 1'b1);
    check_eq("err_mat_valid", mat_valid, 1'b1);
    check_eq("err_data", Data_out, exp_q[0]);

    // Gapped load interrupted by reset after 7 elements.
    set_vals(32'h500);
    do_start(1'b0);
    feed(3, -1, 7, rc);
    n_reset = 1'b0;
    tick();
    check_all_zero("midload_reset");
    exp_q.delete();
    n_reset = 1'b1;
    tick();
    set_vals(32'h600);
    do_start(1'b1);
    exp_q.push_back(build_mat(32'h600, 1'b1));
    feed(3, -1, 16, rc);
    consume("gap_matrix");

    // Non-square 2x3x8 instance.
    s_mat_release = 1'b1;
    tick();
    s_mat_release = 1'b0;
    check_eq("nsq_spurious_valid", s_mat_valid, 1'b0);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'(k + 1);
      tick();
    end
    s_in_valid = 1'b0;
    check_eq("nsq_load_done", s_load_done, 1'b1);
    check_eq("nsq_data", s_Data_out, 48'h060504030201);
    s_mat_release = 1'b1;
    tick();
    check_eq("nsq_released", s_mat_valid, 1'b0);
    tick();
    s_mat_release = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'(k + 8'h11);
      tick();
    end
    s_in_valid = 1'b0;
    check_eq("nsq_second_valid", s_mat_valid, 1'b1);
    check_eq("nsq_second_data", s_Data_out, 48'h161514131211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_b_dbuf_loader.md
Name: matrix_b_dbuf_loader

Overview:
- Streams a ROWS x COLS operand matrix into a double-buffered register store, one DATA_W-bit element per valid/ready handshake.
- Presents the complete matrix as one flat bus to the compute array.
- Supports row-major or column-major fill order per load.
- While the consumer holds one bank, the next matrix loads into the other bank, so compute and load overlap.

Parameters:
ROWS, 4, matrix rows (>=1)
COLS, 4, matrix columns (>=1)
DATA_W, 32, element width in bits

Ports:
clk  in  1  clock, all logic on rising edge
n_reset  in  1  reset, synchronous, active-low
start  in  1  request a new matrix load into the fill bank
col_major  in  1  fill order, sampled with start (0 = row-major, 1 = column-major)
in_valid  in  1  in_data valid
in_data  in  DATA_W  element data
in_ready  out  1  loader accepts an element this cycle
mat_valid  out  1  read bank holds a complete matrix
mat_release  in  1  consumer is finished with the read bank
Data_out  out  ROWS*COLS*DATA_W  read-bank matrix; element (r,c) at bits [(r*COLS+c+1)*DATA_W-1 -: DATA_W]
Busy  out  1  load in progress (state LOAD or WAIT_BANK)
load_done  out  1  one-cycle pulse, last element written
err_start  out  1  one-cycle pulse, start ignored

Behaviour:
- Reset: n_reset=0 at a rising edge clears both banks to 0, bank_full[1:0]=0, fill_bank=0, rd_bank=0, counters=0, state=IDLE. After reset, all outputs are 0. Reset mid-load discards partial and full banks.
- States:
  - IDLE: in_ready=0. On start: latch col_major. Go to LOAD if bank_full[fill_bank]=0, otherwise go to WAIT_BANK.
  - WAIT_BANK: in_ready=0. Move to LOAD in the cycle after bank_full[fill_bank] clears.
  - LOAD: in_ready=1. Each handshake (in_valid & in_ready) writes in_data and advances element index k, 0..ROWS*COLS-1.
- Position mapping:
  - Row-major: r = k/COLS, c = k%COLS.
  - Column-major: r = k%ROWS, c = k/ROWS.
  - Implement with separate r/c counters; no divider.
- Last handshake (k = ROWS*COLS-1): on the same edge, set bank_full[fill_bank]=1, toggle fill_bank, reset counters, and return to IDLE. load_done=1 for the following cycle.
- The write is visible on Data_out one cycle after the handshake when it targets the read bank.
- mat_valid = bank_full[rd_bank].
- Data_out:
  - Combinational from the rd_bank storage, gated to 0 when mat_valid=0.
  - Banks are zeroed only by reset.
- mat_release with mat_valid=1: clear bank_full[rd_bank] and toggle rd_bank on that edge. mat_release with mat_valid=0 is ignored.
- Simultaneous events:
  - Final write to one bank in the same cycle as release of the other: both take effect.
  - Release of the bank WAIT_BANK is waiting on: LOAD is entered the next cycle.
- start in LOAD or WAIT_BANK: ignored, err_start pulses for one cycle, and the load in progress is unaffected.
- in_valid outside LOAD: data dropped, no error flag.
- Busy=1 in LOAD and WAIT_BANK, 0 in IDLE.
- Matrices are consumed in load order; at most two are complete at once.
- Element widths are exact DATA_W; no arithmetic on data. Counter widths are $clog2 of max(ROWS,COLS,2).

Decomposition:
- Shared package matrix_pkg:
  - Default DATA_W.
  - Fill-order enum ORDER_ROW/ORDER_COL.
  - Loader state enum IDLE/LOAD/WAIT_BANK.
  - Element-offset function (r,c)->bit offset, shared by the compute array.
- Sub-module matrix_bank: ROWS*COLS*DATA_W storage with synchronous clear, write enable, row/col index and flat output. Instantiated twice; the top level holds the FSM, counters and bank pointers.

Test Plan:
- Reset, then row-major load of 16 elements 0x10..0x1F with in_valid held high -> in_ready high for exactly 16 cycles; load_done and mat_valid=1 in the cycle after the 16th handshake; element (1,2) reads 0x16.
- Column-major load of values 0..15 -> element (1,2) = 9, element (3,0) = 3.
- Load A, then immediately load B with no release -> B completes; third start goes to WAIT_BANK (Busy=1, in_ready=0); mat_release -> Data_out shows B; third load enters LOAD the cycle after the release.
- start pulsed mid-LOAD after 5 elements -> err_start pulse; load still completes after exactly 16 handshakes.
- Gapped in_valid (1 of every 3 cycles) plus n_reset=0 after 7 elements -> all outputs 0 next cycle; a new start loads from k=0.
- Non-square ROWS=2, COLS=3, DATA_W=8, row-major data 1..6 -> Data_out = 0x060504030201; mat_release with mat_valid=0 has no effect.
